// File: rtl/rv_perf_pkg.sv
// rv_perf_pkg: shared FSM state type and counter index map for the performance monitor
package rv_perf_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOPPED} perf_state_t;
    localparam int CNT_CYCLES   = 0;
    localparam int CNT_INSTRET  = 1;
    localparam int CNT_EVT_BASE = 2;
endpackage

// File: rtl/rv_perf_ctr.sv
// rv_perf_ctr: one wrapping counter with synchronous clear and a sticky wrap flag
module rv_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    // clear beats increment; ovf latches on the all-ones to zero step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
            if (&cnt) ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/rv_perf_mon.sv
// rv_perf_mon: cycle/instret/event counters gated by a start/stop window; PERF_SNAPSHOT_EN adds a readable shadow bank
module rv_perf_mon
    import rv_perf_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int N_EVT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        clr,
    input  logic                        we_rf,
    input  logic                        we_mem,
    input  logic [N_EVT-1:0]            evt,
    input  logic                        snap,
    input  logic [$clog2(N_EVT+2)-1:0]  rd_sel,
    output logic [CNT_W-1:0]            rd_data,
    output logic                        running,
    output logic [N_EVT+1:0]            ovf
);
    localparam int N = N_EVT + 2;

    perf_state_t state, state_nxt;
    logic ret, ret_q, en;
    logic [N-1:0] inc;
    logic [CNT_W-1:0] cnt [N];
    logic [CNT_W-1:0] src [N];

    // window FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // stop dominates start in every state
    always_comb begin
        state_nxt = state;
        if (state == RUN) state_nxt = stop ? STOPPED : RUN;
        else if (start && !stop) state_nxt = RUN;
    end

    // retire history tracks the core in every state so a pre-existing retire is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ret_q <= 1'b0;
        else     ret_q <= ret;
    end

    assign ret     = we_rf | we_mem;
    assign en      = (state == RUN);
    assign running = en;
    assign inc     = {evt & {N_EVT{en}}, en & ret & ~ret_q, en};

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ctr
            rv_perf_ctr #(.CNT_W(CNT_W)) u_ctr (
                .clk (clk),
                .rst (rst),
                .inc (inc[g]),
                .clr (clr),
                .cnt (cnt[g]),
                .ovf (ovf[g])
            );
        end
    endgenerate

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow [N];

    // capture the post-update counter values so the snapshot includes this edge's events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) shadow[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < N; k++) shadow[k] <= '0;
        end else if (snap) begin
            for (int k = 0; k < N; k++) shadow[k] <= cnt[k] + CNT_W'(inc[k]);
        end
    end

    assign src = shadow;
`else
    logic unused_snap;
    assign unused_snap = snap;
    assign src = cnt;
`endif

    assign rd_data = (int'(rd_sel) < N) ? src[rd_sel] : '0;
endmodule

// File: tb/tb_rv_perf_mon.sv
// tb_rv_perf_mon: scoreboard bench with a window/counter reference model; honours PERF_SNAPSHOT_EN
module tb_rv_perf_mon;
    localparam int CW = 4;
    localparam int NE = 4;
    localparam int N  = NE + 2;
    localparam int MOD = 1 << CW;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 0, stop = 0, clr = 0, we_rf = 0, we_mem = 0, snap = 0;
    logic [NE-1:0] evt = '0;
    logic [2:0] rd_sel = '0;
    logic [CW-1:0] rd_data;
    logic running;
    logic [N-1:0] ovf;

    rv_perf_mon #(.CNT_W(CW), .N_EVT(NE)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .we_rf(we_rf), .we_mem(we_mem), .evt(evt), .snap(snap),
        .rd_sel(rd_sel), .rd_data(rd_data), .running(running), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int data;
        bit run;
        bit [N-1:0] ov;
        int ph;
    } exp_t;
    exp_t q[$];

    int errors = 0, checks = 0, ph = 0;

    int m_cnt[N];
    int m_sh[N];
    bit [N-1:0] m_ovf;
    bit m_run, m_prev;

    task automatic chk(input string nm, input int p, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s phase=%0d got=%0d expected=%0d", nm, p, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0;
            m_sh[k] = 0;
        end
        m_ovf = '0;
        m_run = 0;
        m_prev = 0;
    endtask

    function automatic int view(input int sel);
        if (sel >= N) return 0;
`ifdef PERF_SNAPSHOT_EN
        return m_sh[sel];
`else
        return m_cnt[sel];
`endif
    endfunction

    // one clock edge of the monitor described in terms of its rules
    task automatic model_edge();
        bit r;
        r = we_rf | we_mem;
        if (clr) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            m_ovf = '0;
        end else if (m_run) begin
            for (int k = 0; k < N; k++) begin
                bit hit;
                hit = (k == 0) ? 1'b1 : (k == 1) ? (r && !m_prev) : evt[k-2];
                if (hit) begin
                    m_cnt[k] = (m_cnt[k] + 1) % MOD;
                    if (m_cnt[k] == 0) m_ovf[k] = 1;
                end
            end
        end
        if (clr) for (int k = 0; k < N; k++) m_sh[k] = 0;
        else if (snap) for (int k = 0; k < N; k++) m_sh[k] = m_cnt[k];
        if (stop) m_run = 0;
        else if (start) m_run = 1;
        m_prev = r;
    endtask

    // queue the expected outputs for the current model state, then take one edge
    task automatic tick(input int sel);
        exp_t e;
        rd_sel = 3'(sel);
        e.sel = sel;
        e.data = view(sel);
        e.run = m_run;
        e.ov = m_ovf;
        e.ph = ph;
        q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        start = 0; stop = 0; clr = 0; we_rf = 0; we_mem = 0; snap = 0; evt = '0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("rd_data[sel=%0d]", e.sel), e.ph, int'(rd_data), e.data);
            chk("running", e.ph, int'(running), int'(e.run));
            chk("ovf", e.ph, int'(ovf), int'(e.ov));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        ph = 0;
        chk("reset_rd_data", ph, int'(rd_data), 0);
        chk("reset_running", ph, int'(running), 0);
        chk("reset_ovf", ph, int'(ovf), 0);
        rst = 0;

        ph = 1;
        start = 1; tick(0); start = 0;
        for (int k = 0; k < 10; k++) begin
            we_rf = (k % 4 == 1);
            stop = (k == 9);
            tick(k % 2);
        end
        idle_in(); tick(0);
`ifndef PERF_SNAPSHOT_EN
        rd_sel = 0; #1 chk("plan_cycles", ph, int'(rd_data), 10);
        rd_sel = 1; #1 chk("plan_instret", ph, int'(rd_data), 3);
`endif

        ph = 2;
        clr = 1; tick(1); clr = 0;
        start = 1; tick(1); start = 0;
        we_rf = 1; we_mem = 1; tick(1); we_rf = 0; we_mem = 0; tick(1);
        we_rf = 1; repeat (5) tick(1); we_rf = 0; tick(1);
        stop = 1; tick(1); stop = 0; tick(1);
`ifndef PERF_SNAPSHOT_EN
        rd_sel = 1; #1 chk("instret_dual_and_held", ph, int'(rd_data), 2);
`endif

        ph = 3;
        we_rf = 1; clr = 1; tick(1); clr = 0;
        start = 1; tick(1); start = 0;
        repeat (3) tick(1);
        stop = 1; tick(1); stop = 0; we_rf = 0; tick(1);

        ph = 4;
        clr = 1; tick(0); clr = 0;
        start = 1; tick(0); start = 0;
        repeat (17) tick(0);
        chk("wrap_ovf0", ph, int'(ovf[0]), 1);
`ifndef PERF_SNAPSHOT_EN
        rd_sel = 0; #1 chk("wrap_cycles", ph, int'(rd_data), 1);
`endif
        clr = 1; tick(0); clr = 0;
        chk("clr_running_ovf", ph, int'(ovf), 0);
`ifndef PERF_SNAPSHOT_EN
        rd_sel = 0; #1 chk("clr_running_cycles", ph, int'(rd_data), 0);
`endif

        ph = 5;
        start = 1; stop = 1; tick(0); start = 0; stop = 0;
        chk("start_stop_in_run", ph, int'(running), 0);
        for (int k = 0; k < 20; k++) begin
            evt = 4'($urandom); we_rf = 1'($urandom);
            tick(k % N);
        end
        idle_in();
        start = 1; tick(0); start = 0;
        repeat (4) tick(0);

        ph = 6;
        for (int k = 0; k < 300; k++) begin
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 31) == 0);
            snap = ($urandom_range(0, 7) == 0);
            we_rf = 1'($urandom);
            we_mem = ($urandom_range(0, 3) == 0);
            evt = 4'($urandom);
            tick($urandom_range(0, 7));
        end
        idle_in();

        ph = 7;
        stop = 1; tick(0); stop = 0;
        clr = 1; tick(0); clr = 0;
        start = 1; tick(0); start = 0;
        for (int k = 0; k < 13; k++) begin
            snap = (k == 7);
            stop = (k == 12);
            tick(0);
        end
        idle_in(); tick(0);
        rd_sel = 0; #1;
`ifdef PERF_SNAPSHOT_EN
        chk("snapshot_cycles", ph, int'(rd_data), 8);
`else
        chk("snapshot_cycles", ph, int'(rd_data), 13);
`endif

        ph = 8;
        start = 1; tick(0); start = 0;
        we_rf = 1; repeat (3) tick(0); we_rf = 0;
        #1 rst = 1;
        #1;
        model_reset();
        chk("async_rst_rd_data", ph, int'(rd_data), 0);
        chk("async_rst_running", ph, int'(running), 0);
        chk("async_rst_ovf", ph, int'(ovf), 0);
        @(posedge clk); #1 rst = 0;
        start = 1; stop = 1; tick(0); start = 0; stop = 0;
        chk("start_stop_in_idle", ph, int'(running), 0);
        start = 1; tick(0); start = 0;
        repeat (3) tick(0);
        tick(2);
        #10;
        chk("scoreboard_drained", ph, q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
